muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative control and arithmetic stage for the 64-bit shift-add multiplier and restoring divider.
- Sits directly upstream of the 129-bit result register and drives all of its inputs: data_in, initial_data_in, wr, initial_wr, sh_right and sh_left.
- Consumes the register's result output as feedback.
- Latches the operands, runs a 64-iteration FSM, computes the 65-bit add/subtract word each cycle and signals completion.

Parameters:
- N_ITER, 64, number of iterations. Must equal the operand width; only 64 is supported by the result register.
- CNT_W, 7, iteration counter width. Must satisfy 2**CNT_W > N_ITER.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  1  0 = unsigned multiply, 1 = unsigned divide; latched with start
- operand_a  input  64  multiplier (mul) or dividend (div); latched with start
- operand_b  input  64  multiplicand (mul) or divisor (div); latched with start
- result  input  129  feedback from the result register
- data_out  output  65  to result register data_in
- initial_data_out  output  64  to result register initial_data_in; equals latched operand_a
- wr  output  1  register write
- initial_wr  output  1  register initial load
- sh_right  output  1  shift-right strobe (multiply)
- sh_left  output  1  shift-left strobe (divide)
- busy  output  1  high in LOAD and ITER
- done  output  1  one-cycle pulse in DONE
- div_by_zero  output  1  divide-by-zero flag (see Optional Feature)

Behaviour:
- Reset:
  - State goes to IDLE; counter = 0; latched op/A/B = 0.
  - All outputs 0, including data_out and initial_data_out.
  - A reset asserted mid-operation aborts immediately; the next cycle is IDLE with no residual strobes.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - All strobes 0.
  - If start = 1, latch op, operand_a and operand_b, then go to LOAD.
- LOAD (1 cycle):
  - initial_wr = 1, initial_data_out = A, busy = 1; counter cleared.
  - Next state is ITER.
- ITER (N_ITER cycles, counter 0..N_ITER-1):
  - busy = 1; exactly one of sh_right/sh_left is high per cycle.
  - Multiply, sh_right = 1:
    - data_out = {1'b0, result[127:64]} + {1'b0, B}, a 65-bit sum that keeps the carry.
    - wr = result[0].
  - Divide, sh_left = 1:
    - trial = result[127:63] - {1'b0, B}, computed 66 bits wide.
    - wr = 1 when result[127:63] >= B, with data_out = trial[64:0].
    - Otherwise wr = 0, and data_out = trial[64:0] is a don't-care.
  - When counter = N_ITER-1, go to DONE; otherwise increment the counter.
- DONE (1 cycle):
  - done = 1, busy = 0, all register strobes 0.
  - Multiply result: product = result[127:0].
  - Divide result: quotient = result[63:0], remainder = result[128:64].
  - Next state is IDLE.
- Latency:
  - start sampled at edge k: LOAD in cycle k+1, ITER in cycles k+2..k+65, done high in cycle k+66.
  - The result register is final at the start of cycle k+66.
- start while busy or in DONE is ignored: no re-latch and no restart. The next start is accepted in the IDLE cycle that follows DONE.
- Operand inputs may change freely after start is accepted; only the latched copies are used.
- Control outputs are combinational from the state, the latched operands and result. They are never asserted in IDLE.

Optional Feature:
- Macro: MULDIV_DIV0_TRAP_EN.
- Defined:
  - In IDLE, start with op = 1 and operand_b = 0 goes to LOAD, then directly to DONE with no ITER cycles.
  - div_by_zero = 1 together with done, and holds until the next accepted start or reset.
  - The register keeps {65'd0, dividend}.
- Undefined:
  - div_by_zero is tied to 0 and the division runs all 64 iterations.
  - Result: quotient = 64'hFFFF_FFFF_FFFF_FFFF, remainder = dividend.

Test Plan:
- mul A=3, B=5:
  - done at cycle k+66; result[127:0] = 15.
  - sh_right high for exactly 64 cycles; wr high only in iterations 0 and 1.
- mul A=B=64'hFFFF_FFFF_FFFF_FFFF -> result[127:0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. This exercises the carry into data_out[64].
- div A=100, B=7 -> quotient 14, remainder 2.
- div A=5, B=9 -> quotient 0, remainder 5.
- div A=1234, B=0:
  - With the macro: done at cycle k+2, div_by_zero = 1, result = {65'd0, 64'd1234}.
  - Without the macro: quotient all-ones, remainder 1234, div_by_zero = 0.
- Control and abort checks:
  - start pulsed again at cycle k+10 with different operands is ignored; the original product is unchanged.
  - reset at cycle k+30 returns to IDLE next cycle with busy = 0 and all strobes 0.
  - A new start after that reset completes correctly.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative sequencer for a 64-bit shift-add multiplier / restoring divider driving an external 129-bit result register.
// Optional divide-by-zero trap enabled by defining MULDIV_DIV0_TRAP_EN.
module muldiv_sequencer #(
   parameter int N_ITER = 64,
   parameter int CNT_W  = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op,
   input  logic [63:0]   operand_a,
   input  logic [63:0]   operand_b,
   input  logic [128:0]  result,
   output logic [64:0]   data_out,
   output logic [63:0]   initial_data_out,
   output logic          wr,
   output logic          initial_wr,
   output logic          sh_right,
   output logic          sh_left,
   output logic          busy,
   output logic          done,
   output logic          div_by_zero
);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              op_reg;
   logic [63:0]       a_reg, b_reg;

   logic [64:0]       mul_sum;
   logic [65:0]       div_trial;
   logic              rem_ge;
   logic              div0_hit;
   logic              unused_result_bits;

   // Bits of the feedback word that neither datapath looks at.
   assign unused_result_bits = ^{result[128], result[62:1]};

   // Multiply keeps the carry in bit 64; divide uses the borrow in bit 65 as the compare.
   assign mul_sum   = {1'b0, result[127:64]} + {1'b0, b_reg};
   assign div_trial = {1'b0, result[127:63]} - {2'b00, b_reg};
   assign rem_ge    = ~div_trial[65];

   assign initial_data_out = a_reg;

`ifdef MULDIV_DIV0_TRAP_EN
   logic div0_reg;

   assign div0_hit    = op_reg && (b_reg == 64'd0);
   assign div_by_zero = div0_reg;

   // Flag is raised on the LOAD->DONE shortcut and held until the next accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         div0_reg <= 1'b0;
      end else if (state_reg == IDLE && start) begin
         div0_reg <= 1'b0;
      end else if (state_reg == LOAD && div0_hit) begin
         div0_reg <= 1'b1;
      end
   end
`else
   assign div0_hit    = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         op_reg    <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && start) begin
            op_reg <= op;
            a_reg  <= operand_a;
            b_reg  <= operand_b;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      data_out   = '0;
      wr         = 1'b0;
      initial_wr = 1'b0;
      sh_right   = 1'b0;
      sh_left    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            initial_wr = 1'b1;
            busy       = 1'b1;
            cnt_next   = '0;
            state_next = div0_hit ? DONE : ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (op_reg) begin
               sh_left  = 1'b1;
               data_out = div_trial[64:0];
               wr       = rem_ge;
            end else begin
               sh_right = 1'b1;
               data_out = mul_sum;
               wr       = result[0];
            end
            if (cnt_reg == LAST_ITER) begin
               cnt_next   = '0;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
